// File: rtl/mul_booth_seq_if.sv
// Request/response bundle for the iterative Booth multiplier.
// The issue side drives the master modport and the multiplier uses the slave modport.
interface mul_booth_seq_if #(parameter int XLEN = 64);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            op1_signed;
  logic            op2_signed;
  logic            res_hi;
  logic            is_word;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op1, op2, op1_signed, op2_signed, res_hi, is_word, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op1, op2, op1_signed, op2_signed, res_hi, is_word, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier: one Booth2 slice is retired per cycle into a
// 130-bit accumulator. Word ops stop after 16 slices, full-width ops after 33.
module mul_booth_seq #(
  parameter int XLEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  mul_booth_seq_if.slave bus
);
  localparam int ACC_W  = 2*XLEN + 2;
  localparam int MREG_W = XLEN + 3;
  localparam int HALF   = XLEN / 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_ext;
  logic signed [ACC_W-1:0]   w_mcand_ext;
  logic signed [ACC_W-1:0]   w_pp;
  logic signed [ACC_W-1:0]   r_mcand;
  logic signed [MREG_W-1:0]  r_mreg;
  logic signed [ACC_W-1:0]   r_acc;
  logic [5:0]                r_cnt;
  logic [5:0]                r_n;
  logic                      r_is_word;
  logic                      r_res_hi;
  logic                      w_unused_acc;

  function automatic logic signed [ACC_W-1:0] booth2(input logic [2:0] sel,
                                                     input logic signed [ACC_W-1:0] m);
    logic signed [ACC_W-1:0] pp;
    case (sel)
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m <<< 1;
      3'b100:         pp = -(m <<< 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  assign w_ext       = bus.op2_signed & bus.op2[XLEN-1];
  assign w_mcand_ext = {{(ACC_W-XLEN){bus.op1_signed & bus.op1[XLEN-1]}}, bus.op1};
  assign w_pp        = booth2(r_mreg[2:0], r_mcand);
  assign w_last      = (r_cnt == r_n - 6'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (bus.in_valid && !bus.flush) begin
        w_next   = S_CALC;
        w_accept = 1'b1;
      end
      S_CALC: if (w_last) w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Flush wins over both completion and consumer acceptance.
    if (bus.flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mreg    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_n       <= '0;
      r_is_word <= 1'b0;
      r_res_hi  <= 1'b0;
    end else if (w_accept) begin
      r_mcand   <= w_mcand_ext;
      r_mreg    <= {w_ext, w_ext, bus.op2, 1'b0};
      r_acc     <= '0;
      r_cnt     <= '0;
      r_n       <= bus.is_word ? 6'd16 : 6'd33;
      r_is_word <= bus.is_word;
      r_res_hi  <= bus.res_hi;
    end else if (r_state == S_CALC) begin
      // Slice k weighs 4^k: shift the multiplicand up as the multiplier window moves down.
      r_acc   <= r_acc + w_pp;
      r_mcand <= r_mcand <<< 2;
      r_mreg  <= r_mreg >>> 2;
      r_cnt   <= r_cnt + 6'd1;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_is_word ? {{HALF{r_acc[HALF-1]}}, r_acc[HALF-1:0]} :
                         r_res_hi  ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

  assign w_unused_acc = ^r_acc[ACC_W-1:2*XLEN];
endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: directed RV64 multiply cases, backpressure,
// flush and reset behaviour, and randomized ops against a plain-arithmetic model.
module tb_mul_booth_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mul_booth_seq_if #(.XLEN(64)) bus();

  mul_booth_seq #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic sa, input logic sb,
                                          input logic hi, input logic w);
    logic signed [129:0] ea;
    logic signed [129:0] eb;
    logic signed [129:0] p;
    ea = sa ? {{66{a[63]}}, a} : {66'd0, a};
    eb = sb ? {{66{b[63]}}, b} : {66'd0, b};
    p  = ea * eb;
    if (w) return {{32{p[31]}}, p[31:0]};
    return hi ? p[127:64] : p[63:0];
  endfunction

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic sa,
                          input logic sb, input logic hi, input logic w);
    bus.op1 = a; bus.op2 = b; bus.op1_signed = sa; bus.op2_signed = sb;
    bus.res_hi = hi; bus.is_word = w; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble operands after accept; the result must not depend on them.
    bus.op1 = {$urandom, $urandom}; bus.op2 = {$urandom, $urandom};
    bus.op1_signed = 1'($urandom); bus.op2_signed = 1'($urandom);
    bus.res_hi = 1'($urandom); bus.is_word = 1'($urandom);
  endtask

  // cyc counts the accept edge as 1; ready_low stays 1 while in_ready=0 and busy=1.
  task automatic wait_valid(output int cyc, output bit ready_low);
    cyc = 1;
    ready_low = 1'b1;
    while (!bus.out_valid && cyc < 200) begin
      if (bus.in_ready || !bus.busy) ready_low = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sa;
    logic        sb;
    logic        hi;
    logic        w;
    logic [63:0] exp;
    int          lat;
  } dcase_t;

  task automatic test_directed();
    dcase_t tc[7];
    int cyc;
    bit rl;
    tc[0] = '{64'd3, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0, 64'd15, 34};
    tc[1] = '{'1, '1, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 34};
    tc[2] = '{'1, '1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd1, 34};
    tc[3] = '{'1, '1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 34};
    tc[4] = '{'1, '1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    tc[5] = '{'1, '1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd1, 34};
    tc[6] = '{64'h4000_0000, 64'd2, 1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 17};
    for (int i = 0; i < 7; i++) begin
      start_op(tc[i].a, tc[i].b, tc[i].sa, tc[i].sb, tc[i].hi, tc[i].w);
      wait_valid(cyc, rl);
      total++; if (cyc !== tc[i].lat) begin bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, cyc, tc[i].lat); end
      total++; if (rl !== 1'b1) begin bad++; $display("FAIL directed_ready_low[%0d] got=%b want=1", i, rl); end
      total++; if (bus.result !== tc[i].exp) begin bad++; $display("FAIL directed_result[%0d] got=%h want=%h", i, bus.result, tc[i].exp); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit rl;
    logic [63:0] held;
    start_op(64'h4000_0000, 64'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_valid(cyc, rl);
    held = bus.result;
    total++; if (held !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL bp_result got=%h want=ffffffff80000000", held); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", k, bus.out_valid); end
      total++; if (bus.result !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL bp_hold_result[%0d] got=%h want=ffffffff80000000", k, bus.result); end
    end
    consume();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_after_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_flush();
    int cyc;
    bit rl;
    bit seen;
    start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL flush_calc_idle got ready=%b busy=%b want ready=1 busy=0", bus.in_ready, bus.busy); end
    seen = 1'b0;
    repeat (40) begin if (bus.out_valid) seen = 1'b1; @(posedge clk); #1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_valid got=%b want=0", seen); end
    // in_valid together with flush in IDLE must be dropped.
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_idle_accept got busy=%b want=0", bus.busy); end
    start_op(64'd7, -64'sd6, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_valid(cyc, rl);
    total++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFD6) begin bad++; $display("FAIL flush_next_op got=%h want=ffffffffffffffd6", bus.result); end
    // Flush in DONE with out_ready low still returns to IDLE.
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_done got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_op(64'd123, 64'd456, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      begin bad++; $display("FAIL reset_mid_ctrl got ready=%b valid=%b busy=%b want 1/0/0", bus.in_ready, bus.out_valid, bus.busy); end
    total++; if (bus.result !== 64'd0) begin bad++; $display("FAIL reset_mid_result got=%h want=0", bus.result); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin if (bus.out_valid || bus.busy) seen = 1'b1; @(posedge clk); #1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_spurious got=%b want=0", seen); end
  endtask

  task automatic test_random();
    logic [63:0] a, b, exp;
    logic sa, sb, hi, w;
    int cyc;
    bit rl;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: a = '1;
        1: a = 64'h8000_0000_0000_0000;
        2: a = 64'd0;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 4))
        0: b = '1;
        1: b = 64'h8000_0000_0000_0000;
        2: b = 64'h7FFF_FFFF_FFFF_FFFF;
        default: b = {$urandom, $urandom};
      endcase
      sa = 1'($urandom); sb = 1'($urandom); hi = 1'($urandom); w = ($urandom_range(0, 3) == 0);
      exp = ref_mul(a, b, sa, sb, hi, w);
      start_op(a, b, sa, sb, hi, w);
      wait_valid(cyc, rl);
      total++; if (cyc !== (w ? 17 : 34)) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, cyc, w ? 17 : 34); end
      total++; if (bus.result !== exp) begin bad++; $display("FAIL rand_result[%0d] a=%h b=%h sa=%b sb=%b hi=%b w=%b got=%h want=%h", i, a, b, sa, sb, hi, w, bus.result, exp); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      consume();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op1 = '0; bus.op2 = '0; bus.op1_signed = 1'b0; bus.op2_signed = 1'b0;
    bus.res_hi = 1'b0; bus.is_word = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
